// File: rtl/image_spike_encoder.sv
// image_spike_encoder: rate-codes a snapshot of IMAGE into AER spike events over N_TIMESTEPS timesteps.
module image_spike_encoder #(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_BITS      = 8,
  parameter int M               = 8,
  parameter int N_TIMESTEPS     = 16,
  parameter int TS_BITS         = $clog2(N_TIMESTEPS) + 1
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
  input  logic                                  NEW_IMAGE,
  output logic [M-1:0]                          SPIKE_ADDR,
  output logic                                  SPIKE_VALID,
  input  logic                                  SPIKE_READY,
  output logic                                  TIMESTEP_TICK,
  output logic                                  ENCODE_BUSY,
  output logic                                  ENCODE_DONE
);
  typedef enum logic [1:0] {IDLE, SCAN, EMIT, TICK} state_t;
  state_t                                state_q;
  logic [PIXEL_BITS-1:0]                 acc_q [IMAGE_SIZE];
  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] snap_q;
  logic [IMAGE_SIZE_BITS-1:0]            p_q;
  logic [TS_BITS-1:0]                    t_q;
  logic                                  new_image_q;
  logic [M-1:0]                          spike_addr_q;
  logic                                  spike_valid_q;
  logic [PIXEL_BITS:0]                   sum_d;
  logic                                  last_p;
  logic                                  last_t;
  assign sum_d  = {1'b0, acc_q[p_q]} + {1'b0, snap_q[p_q]};
  assign last_p = p_q == IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
  assign last_t = t_q == TS_BITS'(N_TIMESTEPS - 1);
  assign SPIKE_ADDR    = spike_addr_q;
  assign SPIKE_VALID   = spike_valid_q;
  assign TIMESTEP_TICK = state_q == TICK;
  assign ENCODE_DONE   = state_q == TICK && last_t;
  assign ENCODE_BUSY   = state_q != IDLE;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      snap_q        <= '0;
      p_q           <= '0;
      t_q           <= '0;
      new_image_q   <= 1'b0;
      spike_addr_q  <= '0;
      spike_valid_q <= 1'b0;
      for (int i = 0; i < IMAGE_SIZE; i++) acc_q[i] <= '0;
    end else begin
      new_image_q <= NEW_IMAGE;
      case (state_q)
        IDLE: if (NEW_IMAGE && !new_image_q) begin
          snap_q  <= IMAGE;
          p_q     <= '0;
          t_q     <= '0;
          state_q <= SCAN;
          for (int i = 0; i < IMAGE_SIZE; i++) acc_q[i] <= '0;
        end
        SCAN: begin
          acc_q[p_q] <= sum_d[PIXEL_BITS-1:0];
          if (sum_d[PIXEL_BITS]) begin
            spike_addr_q  <= M'(p_q);
            spike_valid_q <= 1'b1;
            state_q       <= EMIT;
          end else if (last_p) state_q <= TICK;
          else p_q <= p_q + IMAGE_SIZE_BITS'(1);
        end
        // p stays frozen while the consumer back-pressures the event
        EMIT: if (SPIKE_READY) begin
          spike_valid_q <= 1'b0;
          if (last_p) state_q <= TICK;
          else begin
            p_q     <= p_q + IMAGE_SIZE_BITS'(1);
            state_q <= SCAN;
          end
        end
        TICK: begin
          p_q <= '0;
          if (last_t) state_q <= IDLE;
          else begin
            t_q     <= t_q + TS_BITS'(1);
            state_q <= SCAN;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_image_spike_encoder.sv
// tb_image_spike_encoder: directed and randomized runs checked against a per-pixel rate model.
module tb_image_spike_encoder;
  localparam int IS = 256, PB = 8, MW = 8, NT = 16;
  logic CLK = 1'b0, RST = 1'b1, NEW_IMAGE = 1'b0, SPIKE_READY = 1'b0;
  logic [IS-1:0][PB-1:0] IMAGE = '0;
  logic [MW-1:0] SPIKE_ADDR;
  logic SPIKE_VALID, TIMESTEP_TICK, ENCODE_BUSY, ENCODE_DONE;
  int checks = 0, errors = 0;
  int pix [IS];

  image_spike_encoder dut (
    .CLK(CLK), .RST(RST), .IMAGE(IMAGE), .NEW_IMAGE(NEW_IMAGE),
    .SPIKE_ADDR(SPIKE_ADDR), .SPIKE_VALID(SPIKE_VALID), .SPIKE_READY(SPIKE_READY),
    .TIMESTEP_TICK(TIMESTEP_TICK), .ENCODE_BUSY(ENCODE_BUSY), .ENCODE_DONE(ENCODE_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_image();
    for (int a = 0; a < IS; a++) IMAGE[a] = PB'(pix[a]);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, SPIKE_VALID, 0);
    chk({tag, "_busy"}, ENCODE_BUSY, 0);
    chk({tag, "_tick"}, TIMESTEP_TICK, 0);
    chk({tag, "_done"}, ENCODE_DONE, 0);
  endtask

  // mode 0: READY always 1; mode 1: READY low until the first spike has waited 10 cycles; mode 2: random READY
  task automatic run_image(input int mode, input bit disturb);
    int exp_ts[$];
    int exp_addr[$];
    int cnt[NT];
    int ts, c, seen, stall, nsp, cum;
    bit prev_stall, finished;
    logic [MW-1:0] prev_addr;
    nsp = 0;
    for (int s = 0; s < NT; s++) cnt[s] = 0;
    for (int s = 1; s <= NT; s++)
      for (int a = 0; a < IS; a++)
        if ((pix[a] * s) / 256 != (pix[a] * (s - 1)) / 256) begin
          exp_ts.push_back(s - 1);
          exp_addr.push_back(a);
          cnt[s-1]++;
          nsp++;
        end
    @(negedge CLK);
    NEW_IMAGE = 1'b0;
    @(negedge CLK);
    load_image();
    NEW_IMAGE = 1'b1;
    SPIKE_READY = (mode == 0);
    ts = 0; c = 0; seen = 0; stall = 0; cum = 0;
    prev_stall = 0; finished = 0; prev_addr = '0;
    while (!finished && c < 30000) begin
      @(negedge CLK);
      c++;
      if (disturb && c == 50) for (int a = 0; a < IS; a++) IMAGE[a] = PB'($urandom);
      if (disturb && c == 60) NEW_IMAGE = 1'b0;
      if (disturb && c == 61) NEW_IMAGE = 1'b1;
      SPIKE_READY = mode == 0 ? 1'b1 : mode == 1 ? (stall >= 10) : 1'($urandom_range(0, 1));
      if (SPIKE_VALID && !SPIKE_READY) stall++;
      if (prev_stall) begin
        chk("hold_valid", SPIKE_VALID, 1);
        chk("hold_addr", SPIKE_ADDR, prev_addr);
      end
      chk("busy", ENCODE_BUSY, 1);
      if (SPIKE_VALID && SPIKE_READY) begin
        chk("spike_expected", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) begin
          chk("spike_addr", SPIKE_ADDR, exp_addr.pop_front());
          chk("spike_ts", ts, exp_ts.pop_front());
        end
        seen++;
      end
      if (ENCODE_DONE) chk("done_with_tick", TIMESTEP_TICK, 1);
      if (TIMESTEP_TICK) begin
        cum += cnt[ts];
        chk("tick_spikes", seen, cnt[ts]);
        if (mode == 0) chk("tick_cycle", c, 257 * (ts + 1) + cum);
        chk("done_on_last_tick", ENCODE_DONE, ts == NT - 1);
        if (ENCODE_DONE) begin
          finished = 1;
          if (mode == 0) chk("done_cycle", c, NT * 257 + nsp);
        end else begin
          ts++;
          seen = 0;
        end
      end
      prev_stall = SPIKE_VALID && !SPIKE_READY;
      prev_addr = SPIKE_ADDR;
    end
    chk("finished", finished, 1);
    chk("timesteps", ts, NT - 1);
    chk("leftover_spikes", exp_addr.size(), 0);
    NEW_IMAGE = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk_quiet("after_done");
    end
  endtask

  initial begin
    int c;
    repeat (3) @(negedge CLK);
    chk_quiet("reset");
    chk("reset_addr", SPIKE_ADDR, 0);
    RST = 1'b0;
    // single mid-grey pixel
    foreach (pix[a]) pix[a] = 0;
    pix[5] = 128;
    run_image(0, 0);
    // blank image
    foreach (pix[a]) pix[a] = 0;
    run_image(0, 0);
    // two saturated pixels plus a dim one, then the same under back-pressure
    pix[0] = 255; pix[1] = 255; pix[7] = 16;
    run_image(0, 0);
    run_image(1, 0);
    // random sparse image, random dense image with random READY and mid-run disturbance
    foreach (pix[a]) pix[a] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : 0;
    run_image(0, 0);
    foreach (pix[a]) pix[a] = int'($urandom_range(0, 255));
    run_image(2, 1);
    // reset while an event is pending, then re-run the single-pixel image
    foreach (pix[a]) pix[a] = 0;
    pix[5] = 128;
    @(negedge CLK);
    load_image();
    NEW_IMAGE = 1'b1;
    SPIKE_READY = 1'b0;
    c = 0;
    while (!SPIKE_VALID && c < 1000) begin
      @(negedge CLK);
      c++;
    end
    chk("abort_reach_emit", SPIKE_VALID, 1);
    RST = 1'b1;
    NEW_IMAGE = 1'b0;
    @(negedge CLK);
    chk_quiet("abort");
    RST = 1'b0;
    run_image(0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
